// File: rtl/iaxi_boot_responder.sv
// rtl/iaxi_boot_responder.sv - boot image read responder with request FIFO and in-order memory port
module iaxi_boot_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_BASE  = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] BOOT_SIZE  = 32'h0000_8000,
   parameter int                    DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  itcm_access_AXI,
   input  logic [ADDR_WIDTH-1:0] itcm_auto_load_addr,
   output logic                  IAXI_ready,
   output logic [DATA_WIDTH-1:0] IAXI_read_data,
   output logic                  IAXI_read_data_valid,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid,
   output logic                  resp_err,
   output logic                  protocol_err,
   output logic [15:0]           served_cnt
);

   localparam int              PW      = $clog2(DEPTH) + 1;
   localparam int              SLOTS   = 1 << PW;
   localparam logic [PW-1:0]   DEPTH_C = PW'(DEPTH);
   localparam logic [PW-1:0]   LAST_C  = PW'(DEPTH - 1);

   logic                  en_q;
   logic [ADDR_WIDTH-1:0] fifo_addr [SLOTS];
   logic                  fifo_oor  [SLOTS];
   logic [PW-1:0]         wr_ptr, rd_ptr, count, inflight;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic [ADDR_WIDTH:0]   req_off;
   logic                  req_oor;
   logic                  unused_addr_bits;

   logic                  head_valid, head_oor;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic                  push, grant, oor_pop, pop, rsp_ok, stray;

   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  valid_q, err_q, perr_q;
   logic [15:0]           served_q;

   // Word-align the request and classify it against the image window; the
   // extra offset bit is the borrow that flags addresses below the base.
   assign req_addr         = {itcm_auto_load_addr[ADDR_WIDTH-1:2], 2'b00};
   assign req_off          = {1'b0, req_addr} - {1'b0, BOOT_BASE};
   assign req_oor          = req_off[ADDR_WIDTH] || (req_off[ADDR_WIDTH-1:0] >= BOOT_SIZE);
   assign unused_addr_bits = ^itcm_auto_load_addr[1:0];

   // Head-of-queue decode and the handshake events derived from it
   always_comb begin
      head_valid = (count != '0);
      head_addr  = fifo_addr[rd_ptr];
      head_oor   = fifo_oor[rd_ptr];
      IAXI_ready = en_q && (count != DEPTH_C);
      push       = itcm_access_AXI && IAXI_ready;
      mem_req    = head_valid && !head_oor && (inflight < DEPTH_C);
      mem_addr   = mem_req ? head_addr : '0;
      grant      = mem_req && mem_gnt;
      // An out-of-range head answers only once every earlier read has drained,
      // so its error response cannot overtake them.
      oor_pop    = head_valid && head_oor && (inflight == '0) && !mem_rvalid;
      pop        = grant || oor_pop;
      rsp_ok     = mem_rvalid && (inflight != '0);
      stray      = mem_rvalid && (inflight == '0);
   end

   // Enable goes high one edge after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) en_q <= 1'b0;
      else     en_q <= 1'b1;
   end

   // Request FIFO storage; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr;
         fifo_oor[wr_ptr]  <= req_oor;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + PW'(1);
            2'b01:   count <= count - PW'(1);
            default: count <= count;
         endcase
      end
   end

   // Outstanding memory reads: up on grant, down on a matched rvalid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         case ({grant, rsp_ok})
            2'b10:   inflight <= inflight + PW'(1);
            2'b01:   inflight <= inflight - PW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Registered response: memory data, or zero with error for out-of-range
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         perr_q   <= 1'b0;
         served_q <= '0;
      end else begin
         valid_q <= rsp_ok || oor_pop;
         err_q   <= oor_pop;
         if (rsp_ok)       rdata_q <= mem_rdata;
         else if (oor_pop) rdata_q <= '0;
         if (rsp_ok || oor_pop) served_q <= served_q + 16'd1;
         if (stray) perr_q <= 1'b1;
      end
   end

   assign IAXI_read_data       = rdata_q;
   assign IAXI_read_data_valid = valid_q;
   assign resp_err             = err_q;
   assign protocol_err         = perr_q;
   assign served_cnt           = served_q;

endmodule

// File: tb/tb_iaxi_boot_responder.sv
// tb/tb_iaxi_boot_responder.sv - directed vector bench for iaxi_boot_responder
module tb_iaxi_boot_responder;

   typedef struct {
      logic        acc;
      logic [31:0] addr;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        ready;
      logic        req;
      logic [31:0] maddr;
      logic        valid;
      logic [31:0] data;
      logic        err;
      logic        perr;
      logic [15:0] served;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        access;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        gnt;
   logic [31:0] rdata;
   logic        rvalid;
   logic        resp_err;
   logic        protocol_err;
   logic [15:0] served_cnt;

   int checks = 0;
   int passed = 0;

   vec_t        tbl [25];
   logic [31:0] exp_q [$];
   logic [31:0] mem_q [$];

   iaxi_boot_responder dut (
      .clk                 (clk),
      .rst                 (rst),
      .itcm_access_AXI     (access),
      .itcm_auto_load_addr (addr),
      .IAXI_ready          (ready),
      .IAXI_read_data      (rd_data),
      .IAXI_read_data_valid(rd_valid),
      .mem_req             (mem_req),
      .mem_addr            (mem_addr),
      .mem_gnt             (gnt),
      .mem_rdata           (rdata),
      .mem_rvalid          (rvalid),
      .resp_err            (resp_err),
      .protocol_err        (protocol_err),
      .served_cnt          (served_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(logic a, logic [31:0] ad, logic g, logic r, logic [31:0] rd,
                               logic rdy, logic rq, logic [31:0] ma, logic v, logic [31:0] d,
                               logic e, logic pe, logic [15:0] s);
      vec_t t;
      t.acc = a;   t.addr = ad;  t.gnt = g;   t.rv = r;     t.rdata = rd;
      t.ready = rdy; t.req = rq; t.maddr = ma; t.valid = v; t.data = d;
      t.err = e;   t.perr = pe;  t.served = s;
      return t;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, " ready"},    32'(ready),        32'h0);
      chk({tag, " data"},     rd_data,           32'h0);
      chk({tag, " valid"},    32'(rd_valid),     32'h0);
      chk({tag, " mem_req"},  32'(mem_req),      32'h0);
      chk({tag, " mem_addr"}, mem_addr,          32'h0);
      chk({tag, " resp_err"}, 32'(resp_err),     32'h0);
      chk({tag, " perr"},     32'(protocol_err), 32'h0);
      chk({tag, " served"},   32'(served_cnt),   32'h0);
   endtask

   initial begin
      int sent;
      int got;
      logic [31:0] e;

      //          acc   addr        gnt   rv    rdata          rdy   req   maddr      vld   data           err   perr  served
      // single read
      tbl[0]  = mk(1'b1,32'h10,   1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'h0,        1'b0,1'b0,16'd0);
      tbl[1]  = mk(1'b0,32'h0,    1'b1,1'b0,32'h0,         1'b1,1'b1,32'h10,  1'b0,32'h0,        1'b0,1'b0,16'd0);
      tbl[2]  = mk(1'b0,32'h0,    1'b0,1'b1,32'hDEADBEEF,  1'b1,1'b0,32'h0,   1'b0,32'h0,        1'b0,1'b0,16'd0);
      tbl[3]  = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b1,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[4]  = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      // backpressure: gnt held low, third request refused
      tbl[5]  = mk(1'b1,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[6]  = mk(1'b1,32'h4,    1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[7]  = mk(1'b1,32'h8,    1'b0,1'b0,32'h0,         1'b0,1'b1,32'h0,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[8]  = mk(1'b1,32'h8,    1'b0,1'b0,32'h0,         1'b0,1'b1,32'h0,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[9]  = mk(1'b0,32'h0,    1'b1,1'b0,32'h0,         1'b0,1'b1,32'h0,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[10] = mk(1'b0,32'h0,    1'b1,1'b0,32'h0,         1'b1,1'b1,32'h4,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[11] = mk(1'b0,32'h0,    1'b0,1'b1,32'h11110000,  1'b1,1'b0,32'h0,   1'b0,32'hDEADBEEF, 1'b0,1'b0,16'd1);
      tbl[12] = mk(1'b0,32'h0,    1'b0,1'b1,32'h22220004,  1'b1,1'b0,32'h0,   1'b1,32'h11110000, 1'b0,1'b0,16'd2);
      tbl[13] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b1,32'h22220004, 1'b0,1'b0,16'd3);
      tbl[14] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'h22220004, 1'b0,1'b0,16'd3);
      // out-of-range request queued behind an in-range read
      tbl[15] = mk(1'b1,32'h20,   1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'h22220004, 1'b0,1'b0,16'd3);
      tbl[16] = mk(1'b1,32'h8000, 1'b1,1'b0,32'h0,         1'b1,1'b1,32'h20,  1'b0,32'h22220004, 1'b0,1'b0,16'd3);
      tbl[17] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'h22220004, 1'b0,1'b0,16'd3);
      tbl[18] = mk(1'b0,32'h0,    1'b0,1'b1,32'hCAFE0020,  1'b1,1'b0,32'h0,   1'b0,32'h22220004, 1'b0,1'b0,16'd3);
      tbl[19] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b1,32'hCAFE0020, 1'b0,1'b0,16'd4);
      tbl[20] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b1,32'h0,        1'b1,1'b0,16'd5);
      tbl[21] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'h0,        1'b0,1'b0,16'd5);
      // stray rvalid while idle
      tbl[22] = mk(1'b0,32'h0,    1'b0,1'b1,32'h12345678,  1'b1,1'b0,32'h0,   1'b0,32'h0,        1'b0,1'b0,16'd5);
      tbl[23] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'h0,        1'b0,1'b1,16'd5);
      tbl[24] = mk(1'b0,32'h0,    1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,   1'b0,32'h0,        1'b0,1'b1,16'd5);

      rst = 1'b1; access = 1'b0; addr = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");

      rst = 1'b0;
      @(negedge clk);
      chk("ready before enable", 32'(ready), 32'h0);

      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         access = tbl[i].acc; addr = tbl[i].addr; gnt = tbl[i].gnt;
         rvalid = tbl[i].rv;  rdata = tbl[i].rdata;
         @(negedge clk);
         chk($sformatf("row%0d ready", i),    32'(ready),        32'(tbl[i].ready));
         chk($sformatf("row%0d mem_req", i),  32'(mem_req),      32'(tbl[i].req));
         chk($sformatf("row%0d mem_addr", i), mem_addr,          tbl[i].maddr);
         chk($sformatf("row%0d valid", i),    32'(rd_valid),     32'(tbl[i].valid));
         chk($sformatf("row%0d data", i),     rd_data,           tbl[i].data);
         chk($sformatf("row%0d resp_err", i), 32'(resp_err),     32'(tbl[i].err));
         chk($sformatf("row%0d perr", i),     32'(protocol_err), 32'(tbl[i].perr));
         chk($sformatf("row%0d served", i),   32'(served_cnt),   32'(tbl[i].served));
      end

      // ordering under random grant/rvalid delays
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 400 && got < 4; cyc++) begin
         @(posedge clk); #1;
         access = (sent < 4) && ($urandom_range(0, 1) == 1);
         addr   = 32'h100 + 32'(sent * 4);
         gnt    = ($urandom_range(0, 2) != 0);
         rvalid = (mem_q.size() != 0) && ($urandom_range(0, 2) == 0);
         rdata  = rvalid ? (mem_q[0] ^ 32'hA5A5A5A5) : 32'h0;
         @(negedge clk);
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               chk("ord unexpected response", 32'(rd_valid), 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("ord resp%0d data", got), rd_data, e ^ 32'hA5A5A5A5);
               chk($sformatf("ord resp%0d err", got), 32'(resp_err), 32'h0);
               got++;
            end
         end
         if (access && ready) begin
            exp_q.push_back(addr);
            sent++;
         end
         if (mem_req && gnt) mem_q.push_back(mem_addr);
         if (rvalid) void'(mem_q.pop_front());
      end
      chk("ord responses received", 32'(got), 32'd4);
      chk("ord served", 32'(served_cnt), 32'd9);

      // reset with two reads in flight
      @(posedge clk); #1;
      access = 1'b1; addr = 32'h40; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      @(posedge clk); #1;
      addr = 32'h44; gnt = 1'b1;
      @(posedge clk); #1;
      access = 1'b0;
      @(negedge clk);
      chk("pre-reset mem_addr", mem_addr, 32'h44);
      @(posedge clk); #1;
      gnt = 1'b0; rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset ready low", 32'(ready), 32'h0);
      @(posedge clk); #1;
      rvalid = 1'b1; rdata = 32'h00000BAD;
      @(negedge clk);
      chk("post-reset ready high", 32'(ready), 32'h1);
      chk("post-reset perr before", 32'(protocol_err), 32'h0);
      @(posedge clk); #1;
      rvalid = 1'b0; rdata = '0;
      @(negedge clk);
      chk("late rvalid perr", 32'(protocol_err), 32'h1);
      chk("late rvalid valid", 32'(rd_valid), 32'h0);
      chk("late rvalid served", 32'(served_cnt), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/iaxi_boot_responder.md
IAXI_BOOT_RESPONDER -- requirements
Module: iaxi_boot_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, read data width.
REQ-003 SHALL have parameter BOOT_BASE, default 32'h0000_0000, first byte address of the served image.
REQ-004 SHALL have parameter BOOT_SIZE, default 32'h0000_8000, image size in bytes.
REQ-005 SHALL have parameter DEPTH, default 2, request FIFO depth and maximum memory reads in flight.
REQ-006 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, reset). One clock; `rst` is asynchronous and active-high.
REQ-007 SHALL have port `itcm_access_AXI` (in, 1): auto-load read request valid.
REQ-008 SHALL have port `itcm_auto_load_addr` (in, ADDR_WIDTH): request byte address. Bits [1:0] are ignored.
REQ-009 SHALL have port `IAXI_ready` (out, 1): responder can accept a request this cycle.
REQ-010 SHALL have ports `IAXI_read_data` (out, DATA_WIDTH) and `IAXI_read_data_valid` (out, 1): response data and its one-cycle valid pulse.
REQ-011 SHALL have ports `mem_req` (out, 1), `mem_addr` (out, ADDR_WIDTH), `mem_gnt` (in, 1), `mem_rdata` (in, DATA_WIDTH) and `mem_rvalid` (in, 1): backing boot-memory port. Latency is variable; responses return in order.
REQ-012 SHALL have ports `resp_err` (out, 1): one-cycle pulse with an out-of-range response. `protocol_err` (out, 1): sticky flag. `served_cnt` (out, 16): count of responses delivered.

Function
REQ-013 SHALL define accept as `itcm_access_AXI && IAXI_ready` in the same cycle.
- Accept pushes {oor, word-aligned addr} into the request FIFO.
- oor = 1 when the addr is below BOOT_BASE or at/above BOOT_BASE+BOOT_SIZE.
REQ-014 SHALL drive `IAXI_ready` = en_q && !fifo_full.
- en_q resets to 0 and sets to 1 on the first clock edge after `rst` deasserts.
REQ-015 SHALL, for an in-range FIFO head with inflight < DEPTH:
- drive `mem_req`=1 and `mem_addr`=head addr;
- pop the head and increment inflight on `mem_req && mem_gnt`;
- hold `mem_req` and `mem_addr` stable until granted.
REQ-016 SHALL pop an oor head only when inflight==0 and no `mem_rvalid` arrives that cycle.
- Popping it issues no `mem_req`.
- Next cycle: `IAXI_read_data`=0, `IAXI_read_data_valid`=1, `resp_err`=1.
REQ-017 SHALL, on `mem_rvalid` with inflight>0:
- register `mem_rdata` into `IAXI_read_data`;
- pulse `IAXI_read_data_valid` for exactly one cycle on the next cycle;
- decrement inflight.
REQ-018 SHALL handle a grant and an rvalid in the same cycle by leaving inflight unchanged.
REQ-019 SHALL handle a push and a pop in the same cycle by leaving FIFO occupancy unchanged. A push into a full FIFO is impossible because `IAXI_ready`=0.
REQ-020 SHALL ignore `mem_rvalid` when inflight==0: set `protocol_err` to 1, with no valid pulse and no counter change.
REQ-021 SHALL hold `IAXI_read_data` at its last value when no response is produced.
REQ-022 SHALL increment `served_cnt` on every `IAXI_read_data_valid` pulse, including oor pulses. It wraps 16'hFFFF -> 0.
REQ-023 SHALL preserve response order equal to accept order.
REQ-024 SHALL meet these minimum latencies:
- accept in cycle N -> `mem_req` in N+1;
- grant in N+1 -> `mem_rvalid` no earlier than N+2;
- `IAXI_read_data_valid` in N+3.
REQ-025 SHALL use FIFO and inflight pointers/counters of width clog2(DEPTH)+1 and never exceed DEPTH.

Reset
REQ-026 SHALL, while `rst`=1, force these outputs to 0: `IAXI_ready`, `IAXI_read_data`, `IAXI_read_data_valid`, `mem_req`, `mem_addr`, `resp_err`, `protocol_err`, `served_cnt`. It SHALL also empty the FIFO and zero inflight.
REQ-027 SHALL apply REQ-026 when reset is asserted mid-operation:
- queued and inflight requests are discarded;
- `mem_rvalid` for pre-reset reads arriving after reset raises `protocol_err`.

Verification
REQ-028 Single read:
- stimulus: addr 32'h10 accepted at N; `mem_gnt`=1 at N+1; `mem_rvalid` with 32'hDEADBEEF at N+2;
- required: `mem_addr`=32'h10 at N+1; valid pulse with data 32'hDEADBEEF at N+3; `served_cnt`=1.
REQ-029 Backpressure:
- stimulus: `mem_gnt`=0 held while requests 0x0, 0x4, 0x8 are offered;
- required: the first two are accepted; `IAXI_ready`=0 at the third; `mem_addr` stays 0x0 until granted.
REQ-030 Ordering:
- stimulus: 4 requests with random gnt/rvalid delays; rdata = addr^32'hA5A5A5A5;
- required: responses arrive in request order with matching data.
REQ-031 Out-of-range:
- stimulus: addr BOOT_BASE+BOOT_SIZE issued behind one in-range read;
- required: no `mem_req` for it; its response has data 0 with `resp_err`=1, after the in-range response.
REQ-032 Protocol error:
- stimulus: `mem_rvalid` pulsed while idle;
- required: `protocol_err`=1 and stays 1; no valid pulse; it clears only on `rst`.
REQ-033 Reset mid-operation:
- stimulus: `rst` asserted with 2 reads in flight;
- required: all outputs are 0 immediately; `IAXI_ready` returns to 1 one clock after release.
